// File: rtl/fpu_pkg.sv
// Shared definitions for the binary64 arithmetic unit: op/rounding codes,
// special encodings, exponent bias, FSM states and the flag bundle.
package fpu_pkg;

  localparam logic [2:0] FPU_ADD = 3'b000;
  localparam logic [2:0] FPU_SUB = 3'b001;
  localparam logic [2:0] FPU_MUL = 3'b010;
  localparam logic [2:0] FPU_DIV = 3'b011;

  localparam logic [1:0] RM_NEAREST = 2'b00;
  localparam logic [1:0] RM_ZERO    = 2'b01;
  localparam logic [1:0] RM_PINF    = 2'b10;
  localparam logic [1:0] RM_NINF    = 2'b11;

  localparam logic [63:0] QNAN   = 64'h7FF8000000000000;
  localparam logic [63:0] PINF   = 64'h7FF0000000000000;
  localparam logic [63:0] MAXFIN = 64'h7FEFFFFFFFFFFFFF;

  localparam int BIAS = 1023;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_EXEC, S_NORM, S_ROUND, S_WAIT, S_DONE
  } fpu_state_e;

  typedef struct packed {
    logic unf;
    logic ovf;
    logic inx;
    logic inv;
    logic dz;
  } fpu_flags_t;

endpackage

// File: rtl/fpu_round.sv
// Rounds a normalized significand (leading 1 at bit 55, GRS below bit 3)
// to binary64, handling carry-out, overflow saturation and flush-to-zero.
module fpu_round
  import fpu_pkg::*;
(
  input  logic               sign,
  input  logic signed [13:0] exp_in,
  input  logic [55:0]        sig,
  input  logic [1:0]         rmode,
  output logic [63:0]        result,
  output logic               overflow,
  output logic               underflow,
  output logic               inexact
);

  logic               lsb, rb, st, inx, up, to_inf;
  logic [53:0]        sum;
  logic signed [13:0] exp_r;
  logic [51:0]        frac_r;

  // Round-increment decision, carry renormalization and range classification
  always_comb begin
    lsb = sig[3];
    rb  = sig[2];
    st  = |sig[1:0];
    inx = rb | st;
    case (rmode)
      RM_NEAREST: up = rb & (st | lsb);
      RM_ZERO:    up = 1'b0;
      RM_PINF:    up = ~sign & inx;
      default:    up = sign & inx;
    endcase
    sum    = {1'b0, sig[55:3]} + {53'b0, up};
    exp_r  = exp_in + $signed({13'b0, sum[53]});
    frac_r = sum[53] ? sum[52:1] : sum[51:0];
    to_inf = (rmode == RM_NEAREST) | ((rmode == RM_PINF) & ~sign) |
             ((rmode == RM_NINF) & sign);

    result    = {sign, 63'b0};
    overflow  = 1'b0;
    underflow = 1'b0;
    inexact   = 1'b0;
    if (sig != '0) begin
      if (exp_r >= 14'sd2047) begin
        overflow = 1'b1;
        inexact  = 1'b1;
        result   = to_inf ? {sign, PINF[62:0]} : {sign, MAXFIN[62:0]};
      end else if (exp_r <= 14'sd0) begin
        underflow = 1'b1;
        inexact   = 1'b1;
      end else begin
        result  = {sign, exp_r[10:0], frac_r};
        inexact = inx;
      end
    end
  end

endmodule

// File: rtl/fpu_double.sv
// Iterative binary64 add/sub/mul/div with a fixed start-to-ready latency.
// One op in flight; a rising edge of enable (re)starts the unit.
module fpu_double
  import fpu_pkg::*;
#(
  parameter int LATENCY = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready,
  output logic        underflow,
  output logic        overflow,
  output logic        inexact,
  output logic        exception,
  output logic        invalid
);

  fpu_state_e         state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [5:0]         step_q, step_d;
  logic               en_prev_q, en_prev_d, ready_q, ready_d;
  logic [63:0]        out_q, out_d, res_q, res_d;
  fpu_flags_t         flg_q, flg_d, pflg_q, pflg_d;
  logic [63:0]        opa_q, opa_d, opb_q, opb_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         rm_q, rm_d;
  logic               sign_q, sign_d;
  logic signed [13:0] exp_q, exp_d;
  logic [56:0]        sig_q, sig_d;
  logic [52:0]        mb_q, mb_d;
  logic [105:0]       acc_q, acc_d, aux_q, aux_d;

  logic               start;
  logic [10:0]        ea, eb;
  logic               sa, sb_eff, sx, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [52:0]        mant_a, mant_b;
  logic signed [13:0] ea_x, eb_x;
  logic               sp_hit;
  logic [63:0]        sp_res;
  fpu_flags_t         sp_flg;
  logic               swap, big_s, small_s, add_sign;
  logic [10:0]        big_e, small_e, ediff;
  logic [52:0]        big_m, small_m;
  logic [56:0]        big_x, small_x, small_al, add_sum;
  logic [105:0]       prod_sum;
  logic [54:0]        rem, rem_nxt;
  logic               q_bit;
  logic [5:0]         lz_pos, nsh;
  logic [56:0]        norm_sig;
  logic signed [13:0] norm_exp;
  logic [63:0]        rnd_res;
  logic               rnd_ovf, rnd_unf, rnd_inx;

  assign start  = enable & ~en_prev_q;
  assign ea     = opa_q[62:52];
  assign eb     = opb_q[62:52];
  assign sa     = opa_q[63];
  assign sb_eff = opb_q[63] ^ (op_q == FPU_SUB);
  assign sx     = opa_q[63] ^ opb_q[63];
  assign a_zero = (ea == 11'd0);
  assign b_zero = (eb == 11'd0);
  assign a_inf  = (&ea) & (opa_q[51:0] == '0);
  assign b_inf  = (&eb) & (opb_q[51:0] == '0);
  assign a_nan  = (&ea) & (opa_q[51:0] != '0);
  assign b_nan  = (&eb) & (opb_q[51:0] != '0);
  assign mant_a = {1'b1, opa_q[51:0]};
  assign mant_b = {1'b1, opb_q[51:0]};
  assign ea_x   = $signed({3'b0, ea});
  assign eb_x   = $signed({3'b0, eb});

  // Special operands resolve directly without entering the arithmetic datapath
  always_comb begin
    sp_hit = 1'b0;
    sp_res = QNAN;
    sp_flg = '0;
    if (op_q[2] | a_nan | b_nan) begin
      sp_hit = 1'b1; sp_flg.inv = 1'b1;
    end else if (!op_q[1]) begin
      if (a_inf & b_inf & (sa != sb_eff)) begin
        sp_hit = 1'b1; sp_flg.inv = 1'b1;
      end else if (a_inf) begin
        sp_hit = 1'b1; sp_res = {sa, PINF[62:0]};
      end else if (b_inf) begin
        sp_hit = 1'b1; sp_res = {sb_eff, PINF[62:0]};
      end else if (a_zero & b_zero) begin
        sp_hit = 1'b1; sp_res = {(sa == sb_eff) ? sa : (rm_q == RM_NINF), 63'b0};
      end else if (a_zero) begin
        sp_hit = 1'b1; sp_res = {sb_eff, opb_q[62:0]};
      end else if (b_zero) begin
        sp_hit = 1'b1; sp_res = {sa, opa_q[62:0]};
      end
    end else if (!op_q[0]) begin
      if ((a_zero & b_inf) | (a_inf & b_zero)) begin
        sp_hit = 1'b1; sp_flg.inv = 1'b1;
      end else if (a_inf | b_inf) begin
        sp_hit = 1'b1; sp_res = {sx, PINF[62:0]};
      end else if (a_zero | b_zero) begin
        sp_hit = 1'b1; sp_res = {sx, 63'b0};
      end
    end else begin
      if ((a_zero & b_zero) | (a_inf & b_inf)) begin
        sp_hit = 1'b1; sp_flg.inv = 1'b1;
      end else if (a_inf) begin
        sp_hit = 1'b1; sp_res = {sx, PINF[62:0]};
      end else if (b_inf) begin
        sp_hit = 1'b1; sp_res = {sx, 63'b0};
      end else if (b_zero) begin
        sp_hit = 1'b1; sp_res = {sx, PINF[62:0]}; sp_flg.dz = 1'b1;
      end else if (a_zero) begin
        sp_hit = 1'b1; sp_res = {sx, 63'b0};
      end
    end
  end

  // Arithmetic step logic: aligned add, one shift-add multiply step, one restoring divide step
  always_comb begin
    swap     = opa_q[62:0] < opb_q[62:0];
    big_m    = swap ? mant_b : mant_a;
    small_m  = swap ? mant_a : mant_b;
    big_e    = swap ? eb : ea;
    small_e  = swap ? ea : eb;
    big_s    = swap ? sb_eff : sa;
    small_s  = swap ? sa : sb_eff;
    ediff    = big_e - small_e;
    big_x    = {1'b0, big_m, 3'b0};
    small_x  = {1'b0, small_m, 3'b0};
    if (ediff > 11'd56) small_al = 57'd1;
    else small_al = (small_x >> ediff) |
                    {56'b0, |(small_x & ~({57{1'b1}} << ediff))};
    add_sum  = (big_s == small_s) ? big_x + small_al : big_x - small_al;
    add_sign = (add_sum == '0) ? (rm_q == RM_NINF) : big_s;

    prod_sum = acc_q + (mb_q[0] ? aux_q : '0);

    rem     = acc_q[54:0];
    q_bit   = rem >= {2'b0, mb_q};
    rem_nxt = q_bit ? rem - {2'b0, mb_q} : rem;
  end

  // Leading-one normalization of the raw significand
  always_comb begin
    lz_pos = '0;
    for (int i = 0; i < 56; i++) if (sig_q[i]) lz_pos = 6'(i);
    nsh = 6'd55 - lz_pos;
    if (sig_q[56]) begin
      norm_sig = {1'b0, sig_q[56:2], sig_q[1] | sig_q[0]};
      norm_exp = exp_q + 14'sd1;
    end else if (sig_q == '0) begin
      norm_sig = sig_q;
      norm_exp = exp_q;
    end else begin
      norm_sig = sig_q << nsh;
      norm_exp = exp_q - $signed({8'b0, nsh});
    end
  end

  fpu_round u_round (
    .sign      (sign_q),
    .exp_in    (exp_q),
    .sig       (sig_q[55:0]),
    .rmode     (rm_q),
    .result    (rnd_res),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf),
    .inexact   (rnd_inx)
  );

  // Next-state and datapath sequencing; a start edge overrides everything
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  step_d = step_q;  en_prev_d = enable;
    ready_d = ready_q;  out_d = out_q;  flg_d = flg_q;    pflg_d = pflg_q;
    res_d = res_q;      opa_d = opa_q;  opb_d = opb_q;    op_d = op_q;
    rm_d = rm_q;        sign_d = sign_q; exp_d = exp_q;   sig_d = sig_q;
    mb_d = mb_q;        acc_d = acc_q;  aux_d = aux_q;
    if (start) begin
      opa_d = opa;  opb_d = opb;  op_d = fpu_op;  rm_d = rmode;
      ready_d = 1'b0;  flg_d = '0;  cnt_d = '0;  state_d = S_UNPACK;
    end else begin
      if (state_q != S_IDLE && state_q != S_DONE) cnt_d = cnt_q + 7'd1;
      case (state_q)
        S_UNPACK: begin
          step_d = '0;
          mb_d   = mant_b;
          sign_d = sx;
          if (sp_hit) begin
            res_d = sp_res;  pflg_d = sp_flg;  state_d = S_WAIT;
          end else begin
            state_d = S_EXEC;
            if (op_q == FPU_MUL) begin
              exp_d = ea_x + eb_x - 14'(BIAS);
              acc_d = '0;
              aux_d = {53'b0, mant_a};
            end else begin
              exp_d = ea_x - eb_x + 14'(BIAS);
              acc_d = {53'b0, mant_a};
              aux_d = '0;
            end
          end
        end
        S_EXEC: begin
          step_d = step_q + 6'd1;
          if (op_q == FPU_MUL) begin
            acc_d = prod_sum;
            aux_d = aux_q << 1;
            mb_d  = mb_q >> 1;
            if (step_q == 6'd52) begin
              sig_d   = prod_sum[105:49] | {56'b0, |prod_sum[48:0]};
              state_d = S_NORM;
            end
          end else if (op_q == FPU_DIV) begin
            acc_d = {50'b0, rem_nxt, 1'b0};
            aux_d = {aux_q[104:0], q_bit};
            if (step_q == 6'd55) begin
              sig_d   = {1'b0, aux_q[54:0], q_bit | (rem_nxt != '0)};
              state_d = S_NORM;
            end
          end else begin
            sign_d  = add_sign;
            exp_d   = $signed({3'b0, big_e});
            sig_d   = add_sum;
            state_d = S_NORM;
          end
        end
        S_NORM: begin
          sig_d = norm_sig;  exp_d = norm_exp;  state_d = S_ROUND;
        end
        S_ROUND: begin
          res_d   = rnd_res;
          pflg_d  = '{unf: rnd_unf, ovf: rnd_ovf, inx: rnd_inx, inv: 1'b0, dz: 1'b0};
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 7'(LATENCY - 1)) begin
            out_d = res_q;  flg_d = pflg_q;  ready_d = 1'b1;  state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and visible outputs, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      en_prev_q <= 1'b0;
      ready_q   <= 1'b0;
      out_q     <= '0;
      flg_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_prev_q <= en_prev_d;
      ready_q   <= ready_d;
      out_q     <= out_d;
      flg_q     <= flg_d;
    end
  end

  // Datapath registers, always reinitialized before use
  always_ff @(posedge clk) begin
    step_q <= step_d;  res_q <= res_d;  pflg_q <= pflg_d;
    opa_q  <= opa_d;   opb_q <= opb_d;  op_q   <= op_d;    rm_q <= rm_d;
    sign_q <= sign_d;  exp_q <= exp_d;  sig_q  <= sig_d;
    mb_q   <= mb_d;    acc_q <= acc_d;  aux_q  <= aux_d;
  end

  assign out       = out_q;
  assign ready     = ready_q;
  assign underflow = flg_q.unf;
  assign overflow  = flg_q.ovf;
  assign inexact   = flg_q.inx;
  assign invalid   = flg_q.inv;
  assign exception = flg_q.inv | flg_q.ovf | flg_q.unf | flg_q.dz;

endmodule

// File: tb/tb_fpu_double.sv
// Scoreboard bench for fpu_double: stimulus pushes expected results, a monitor
// pops and compares on each rising edge of ready.
module tb_fpu_double;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [1:0]  rmode;
  logic [2:0]  fpu_op;
  logic [63:0] opa, opb, out;
  logic        ready, underflow, overflow, inexact, exception, invalid;

  fpu_double dut (
    .clk(clk), .rst(rst), .enable(enable), .rmode(rmode), .fpu_op(fpu_op),
    .opa(opa), .opb(opb), .out(out), .ready(ready), .underflow(underflow),
    .overflow(overflow), .inexact(inexact), .exception(exception), .invalid(invalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [4:0]  flg;   // {underflow, overflow, inexact, exception, invalid}
    int          start;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each presented result against the oldest expectation
  initial begin : monitor
    logic rdy_prev;
    exp_t e;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready === 1'b1 && rdy_prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: ready=1 at cycle %0d, required 0", cyc);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_out"}, out, e.res);
          check({e.name, "_flags"}, 64'({underflow, overflow, inexact, exception, invalid}),
                64'(e.flg));
          check({e.name, "_latency"}, 64'(cyc - e.start), 64'd64);
        end
      end
      rdy_prev = ready;
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                       input logic [1:0] rm, input string name, input logic [63:0] res,
                       input logic [4:0] flg, input bit push, input int hold);
    exp_t e;
    @(negedge clk);
    opa = a; opb = b; fpu_op = op; rmode = rm; enable = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.name = name; e.res = res; e.flg = flg; e.start = cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    repeat (hold - 1) @(negedge clk);
    enable = 1'b0;
    opa = 64'hDEADBEEFCAFEF00D; opb = 64'h0123456789ABCDEF; fpu_op = 3'b111; rmode = 2'b11;
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                     input logic [1:0] rm, input string name, input logic [63:0] res,
                     input logic [4:0] flg);
    issue(a, b, op, rm, name, res, flg, 1'b1, 1);
    repeat (70) @(negedge clk);
    check({name, "_ready_held"}, 64'(ready), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [63:0] a, b, res;
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs[$];

  initial begin : stim
    rst = 1'b1; enable = 1'b0; rmode = 2'b00; fpu_op = 3'b000; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_out", out, 64'd0);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_flags", 64'({underflow, overflow, inexact, exception, invalid}), 64'd0);

    vecs = '{
      '{"add_1p1",    64'h3FF0000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 3'b000, 2'b00, 5'b00000},
      '{"sub_1m075",  64'h3FF0000000000000, 64'h3FE8000000000000, 64'h3FD0000000000000, 3'b001, 2'b00, 5'b00000},
      '{"mul_1p5x2",  64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 3'b010, 2'b00, 5'b00000},
      '{"div_third_rne", 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 3'b011, 2'b00, 5'b00100},
      '{"div_third_up",  64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555556, 3'b011, 2'b10, 5'b00100},
      '{"mul_ovf_rne", 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 3'b010, 2'b00, 5'b01110},
      '{"mul_ovf_rz",  64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FEFFFFFFFFFFFFF, 3'b010, 2'b01, 5'b01110},
      '{"div_by_zero", 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 3'b011, 2'b00, 5'b00010},
      '{"inf_minus_inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 3'b001, 2'b00, 5'b00011},
      '{"op_invalid",  64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 3'b101, 2'b00, 5'b00011},
      '{"zero_sum_rdn", 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 3'b001, 2'b11, 5'b00000},
      '{"zero_sum_rne", 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 3'b001, 2'b00, 5'b00000},
      '{"mul_underflow", 64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, 3'b010, 2'b00, 5'b10110},
      '{"subnormal_in", 64'h0000000000000001, 64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000, 2'b00, 5'b00000}
    };
    foreach (vecs[i])
      run(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rm, vecs[i].name, vecs[i].res, vecs[i].flg);

    // Enable held high for 10 clocks starts exactly one op
    issue(64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000, 2'b00, "hold_enable",
          64'h4000000000000000, 5'b00000, 1'b1, 10);
    repeat (140) @(negedge clk);

    // Re-pulse 30 clocks in restarts; only the second op completes
    issue(64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000, 2'b00, "aborted",
          64'h0, 5'b0, 1'b0, 1);
    repeat (28) @(negedge clk);
    issue(64'h3FF8000000000000, 64'h4000000000000000, 3'b010, 2'b00, "restart",
          64'h4008000000000000, 5'b00000, 1'b1, 1);
    repeat (70) @(negedge clk);
    check("restart_ready_held", 64'(ready), 64'd1);

    // Reset 20 clocks into an op aborts it
    issue(64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000, 2'b00, "rst_abort",
          64'h0, 5'b0, 1'b0, 1);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midop_reset_out", out, 64'd0);
    check("midop_reset_ready", 64'(ready), 64'd0);
    repeat (100) @(negedge clk);
    check("rst_abort_ready", 64'(ready), 64'd0);

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_ready: %0d results outstanding, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
